car_counter: RTL and testbench
==============================

CAR_COUNTER -- requirements
Module: car_counter

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 15, meaning the lot capacity (the saturation ceiling of count); legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port inc, input, 1 bit: car-entry request, sampled every rising edge of clk.
REQ-005 SHALL have port dec, input, 1 bit: car-exit request, sampled every rising edge of clk.
REQ-006 SHALL have port count, output, 4 bits: registered number of cars currently in the lot, unsigned.
REQ-007 SHALL have port err, output, 1 bit: registered error flag for an illegal request (overflow or underflow).

Function
REQ-008 SHALL evaluate requests on every rising edge of clk with rst low; inc and dec are level-sensitive, so one request is counted per cycle held high.
REQ-009 SHALL, when inc=1, dec=0 and count<MAX_COUNT, load count+1 and clear err.
REQ-010 SHALL, when inc=1, dec=0 and count==MAX_COUNT, hold count (no wrap to 0) and set err.
REQ-011 SHALL, when dec=1, inc=0 and count>0, load count-1 and clear err.
REQ-012 SHALL, when dec=1, inc=0 and count==0, hold count at 0 (no wrap to 15) and set err.
REQ-013 SHALL, when inc=1 and dec=1 together, hold count and clear err at every count value, including 0 and MAX_COUNT.
REQ-014 SHALL, when inc=0 and dec=0, hold count and clear err.
REQ-015 SHALL update count and err with one-cycle latency: the new values are visible after the edge that sampled the request; there is no combinational path from inputs to outputs.
REQ-016 SHALL never let count exceed MAX_COUNT or go below 0.

Reset
REQ-017 SHALL, on a rising edge with rst=1, set count=0 and err=0, with priority over inc and dec.
REQ-018 SHALL apply reset mid-operation in the same way, discarding any pending count.

Configuration
REQ-019 SHALL support macro CAR_COUNTER_STICKY_ERR_EN; when it is defined, err stays at 1 once set until the next reset, and count rules are unchanged.
REQ-020 SHALL, when CAR_COUNTER_STICKY_ERR_EN is undefined, clear err as defined in REQ-009 to REQ-014, so err is a per-cycle flag.

Structure
REQ-021 SHALL place the count width constant (4) and the default capacity constant (15) in shared package car_counter_pkg.
REQ-022 SHALL be one flat module with no sub-module; the next-state logic and register fit in a single always block plus a combinational decode.

Verification
REQ-023 SHALL cover fill to saturation: reset for 2 cycles, then inc=1 for 20 cycles -> count runs 1..15 over the first 15 edges; on the last 5 edges count stays 15 and err=1.
REQ-024 SHALL cover drain to empty: from count=15, inc=0 and dec=1 for 20 cycles -> count runs 14..0 over the first 15 edges, err=0 while decrementing; on the last 5 edges count stays 0 and err=1.
REQ-025 SHALL cover underflow after reset: rst=1 for 2 cycles, then dec=1 -> count stays 0 and err=1 from the first edge after reset.
REQ-026 SHALL cover simultaneous requests: inc=dec=1 at count=0, 7 and 15 -> count unchanged and err=0.
REQ-027 SHALL cover reset mid-operation: at count=9 with inc=1, assert rst for 1 cycle -> count=0 and err=0 next edge, then counting resumes at 1.
REQ-028 SHALL cover the sticky build: with CAR_COUNTER_STICKY_ERR_EN defined, overflow and then dec -> count decrements and err stays 1 until rst.

Source files
------------

// File: rtl/car_counter_pkg.sv
// -----------------------------------------------------------------------------
// car_counter_pkg
//   Shared constants and types for the parking-lot car counter.
//
//   Contents:
//     CNT_W              width of the car count (4 bits, capacity up to 15)
//     DEFAULT_MAX_COUNT  default lot capacity (15)
//     req_e              decoded request kind for one clock cycle
//     decode_req()       maps the raw inc/dec levels onto req_e
// -----------------------------------------------------------------------------
package car_counter_pkg;

  localparam int CNT_W             = 4;
  localparam int DEFAULT_MAX_COUNT = 15;

  // One request kind per cycle; inc and dec together cancel out.
  typedef enum logic [1:0] {
    REQ_IDLE = 2'b00,
    REQ_DEC  = 2'b01,
    REQ_INC  = 2'b10,
    REQ_BOTH = 2'b11
  } req_e;

  function automatic req_e decode_req(input logic inc, input logic dec);
    return req_e'({inc, dec});
  endfunction

endpackage : car_counter_pkg

// File: rtl/car_counter.sv
// -----------------------------------------------------------------------------
// car_counter
//   Saturating up/down counter of cars in a parking lot. Each cycle with inc
//   high admits one car, each cycle with dec high releases one. Requests that
//   would push the count above the capacity or below zero are refused: the
//   count holds and err is raised for that cycle. inc and dec together hold
//   the count and are not an error.
//
//   Parameters:
//     MAX_COUNT  lot capacity, saturation ceiling of count (legal 1..15)
//
//   Ports:
//     clk    in   rising-edge clock
//     rst    in   synchronous active-high reset (priority over inc/dec)
//     inc    in   car-entry request, level-sensitive
//     dec    in   car-exit request, level-sensitive
//     count  out  registered number of cars in the lot
//     err    out  registered overflow/underflow flag
//
//   Build option:
//     CAR_COUNTER_STICKY_ERR_EN  when defined, err stays set once raised until
//                                the next reset; count behaviour is unchanged.
// -----------------------------------------------------------------------------
module car_counter
  import car_counter_pkg::*;
#(
  parameter int MAX_COUNT = DEFAULT_MAX_COUNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  localparam logic [CNT_W-1:0] MAX_Q  = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] ZERO_Q = '0;
  localparam logic [CNT_W-1:0] ONE_Q  = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q,   err_d;
  req_e             req;
  logic             at_max;
  logic             at_zero;
  logic             illegal;

  // Combinational decode of this cycle's request against the current count.
  assign req     = decode_req(inc, dec);
  assign at_max  = (count_q == MAX_Q);
  assign at_zero = (count_q == ZERO_Q);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    count_d = count_q;
    illegal = 1'b0;

    unique case (req)
      REQ_INC: begin
        if (at_max) illegal = 1'b1;
        else        count_d = count_q + ONE_Q;
      end
      REQ_DEC: begin
        if (at_zero) illegal = 1'b1;
        else         count_d = count_q - ONE_Q;
      end
      REQ_BOTH,
      REQ_IDLE: count_d = count_q;
      default:  count_d = count_q;
    endcase

`ifdef CAR_COUNTER_STICKY_ERR_EN
    // Once raised, the flag latches until reset.
    err_d = err_q | illegal;
`else
    // Per-cycle flag: any legal cycle clears it.
    err_d = illegal;
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= ZERO_Q;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign err   = err_q;

endmodule : car_counter

// File: tb/tb_car_counter.sv
// -----------------------------------------------------------------------------
// tb_car_counter
//   Self-checking bench for car_counter (MAX_COUNT = 15). Inputs are driven on
//   the falling edge; the expected {count, err} for that cycle is pushed to a
//   scoreboard queue and popped/compared 1 ns after the next rising edge.
//   When CAR_COUNTER_STICKY_ERR_EN is defined the expected err is widened to
//   stay high from the first expected error until the next reset.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_car_counter;

  localparam int MAXC = 15;
`ifdef CAR_COUNTER_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic [3:0] count;
  logic       err;

  car_counter #(.MAX_COUNT(MAXC)) dut (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .dec   (dec),
    .count (count),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] c;
    logic       e;
  } exp_t;

  typedef struct {
    logic       r;
    logic       i;
    logic       d;
    logic [3:0] c;
    logic       e;
  } vec_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   sticky_seen = 1'b0;

  task automatic check(input string name, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got count=%0d err=%0b, expected count=%0d err=%0b",
               name, got.c, got.e, want.c, want.e);
    end
  endtask

  // One clock cycle: drive, push expectation, wait for the edge, pop, compare.
  task automatic apply(input string name, input logic r, input logic i,
                       input logic d, input int ec, input logic ee);
    exp_t want;
    exp_t got;
    @(negedge clk);
    rst = r;
    inc = i;
    dec = d;
    if (r)       sticky_seen = 1'b0;
    else if (ee) sticky_seen = 1'b1;
    want.c = 4'(ec);
    want.e = ee | (STICKY & sticky_seen & ~r);
    sb_q.push_back(want);
    @(posedge clk);
    #1;
    got.c = count;
    got.e = err;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      check(name, got, sb_q.pop_front());
    end
  endtask

  // Watchdog: the run is a few hundred cycles; never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[$];

    // Mixed patterns around mid-range values, ending with a mid-run reset.
    vecs = '{
      '{1'b1, 1'b0, 1'b0,  0, 1'b0},   // clean start
      '{1'b0, 1'b1, 1'b0,  1, 1'b0},
      '{1'b0, 1'b1, 1'b0,  2, 1'b0},
      '{1'b0, 1'b1, 1'b0,  3, 1'b0},
      '{1'b0, 1'b1, 1'b0,  4, 1'b0},
      '{1'b0, 1'b1, 1'b0,  5, 1'b0},
      '{1'b0, 1'b1, 1'b0,  6, 1'b0},
      '{1'b0, 1'b1, 1'b0,  7, 1'b0},
      '{1'b0, 1'b1, 1'b1,  7, 1'b0},   // both at 7
      '{1'b0, 1'b0, 1'b0,  7, 1'b0},   // idle
      '{1'b0, 1'b0, 1'b1,  6, 1'b0},
      '{1'b0, 1'b1, 1'b0,  7, 1'b0},
      '{1'b0, 1'b1, 1'b0,  8, 1'b0},
      '{1'b0, 1'b1, 1'b0,  9, 1'b0},
      '{1'b1, 1'b1, 1'b0,  0, 1'b0},   // reset at 9 while inc held
      '{1'b0, 1'b1, 1'b0,  1, 1'b0},   // counting resumes
      '{1'b0, 1'b1, 1'b0,  2, 1'b0}
    };

    // Reset for two cycles, inc held to show reset priority.
    apply("reset0", 1'b1, 1'b1, 1'b0, 0, 1'b0);
    apply("reset1", 1'b1, 1'b1, 1'b0, 0, 1'b0);

    // Fill to saturation: 1..15, then 5 refused entries.
    for (int k = 0; k < 20; k++)
      apply($sformatf("fill%0d", k), 1'b0, 1'b1, 1'b0,
            (k < MAXC) ? k + 1 : MAXC, (k >= MAXC));

    // Simultaneous request at full clears err, holds count.
    apply("both_at_15", 1'b0, 1'b1, 1'b1, MAXC, 1'b0);

    // Drain to empty: 14..0, then 5 refused exits.
    for (int k = 0; k < 20; k++)
      apply($sformatf("drain%0d", k), 1'b0, 1'b0, 1'b1,
            (k < MAXC) ? MAXC - 1 - k : 0, (k >= MAXC));

    apply("both_at_0", 1'b0, 1'b1, 1'b1, 0, 1'b0);

    // Underflow straight after reset.
    apply("uf_rst0", 1'b1, 1'b0, 1'b1, 0, 1'b0);
    apply("uf_rst1", 1'b1, 1'b0, 1'b1, 0, 1'b0);
    apply("uf_dec0", 1'b0, 1'b0, 1'b1, 0, 1'b1);
    apply("uf_dec1", 1'b0, 1'b0, 1'b1, 0, 1'b1);
    apply("uf_idle", 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Table-driven vectors.
    foreach (vecs[n])
      apply($sformatf("vec%0d", n), vecs[n].r, vecs[n].i, vecs[n].d,
            int'(vecs[n].c), vecs[n].e);

    // Overflow then exits: err per-cycle by default, held in sticky build.
    apply("st_rst", 1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int k = 0; k < MAXC; k++)
      apply($sformatf("st_fill%0d", k), 1'b0, 1'b1, 1'b0, k + 1, 1'b0);
    apply("st_ovf",  1'b0, 1'b1, 1'b0, MAXC,     1'b1);
    apply("st_dec0", 1'b0, 1'b0, 1'b1, MAXC - 1, 1'b0);
    apply("st_dec1", 1'b0, 1'b0, 1'b1, MAXC - 2, 1'b0);
    apply("st_idle", 1'b0, 1'b0, 1'b0, MAXC - 2, 1'b0);
    apply("st_rst2", 1'b1, 1'b0, 1'b0, 0,        1'b0);
    apply("st_post", 1'b0, 1'b0, 1'b0, 0,        1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_car_counter
